// File: rtl/aes_encrypt_controller.sv
// AES-128 single-block encryption sequencer with key-schedule caching.
// Drives key memory and an external combinational round unit.
module aes_encrypt_controller #(
    parameter int EXPAND_TIMEOUT = 32,
    parameter bit KEY_CACHE_EN   = 1'b1
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         req_valid_in,
    output logic         req_ready_out,
    input  logic [127:0] req_key_in,
    input  logic [127:0] req_data_in,
    output logic         resp_valid_out,
    input  logic         resp_ready_in,
    output logic [127:0] resp_data_out,
    output logic         resp_err_out,
    input  logic         key_invalidate_in,
    output logic         km_init_out,
    output logic [127:0] km_key_out,
    input  logic         km_key_expanded_in,
    output logic [3:0]   km_round_rd_out,
    input  logic [127:0] km_round_key_in,
    output logic [127:0] rnd_state_out,
    output logic [127:0] rnd_key_out,
    output logic         rnd_last_out,
    input  logic [127:0] rnd_result_in,
    output logic         busy_out
);

    typedef enum logic [2:0] {
        IDLE,
        EXPAND,
        WHITEN,
        ROUND,
        DONE
    } state_t;

    localparam int TW = $clog2(EXPAND_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(EXPAND_TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [127:0]  key_reg;
    logic [127:0]  key_nxt;
    logic [127:0]  data_reg;
    logic [127:0]  data_nxt;
    logic          cache_valid;
    logic          cache_nxt;
    logic          err_reg;
    logic          err_nxt;
    logic [TW-1:0] tmo;
    logic [TW-1:0] tmo_nxt;
    logic [3:0]    rnd;
    logic [3:0]    rnd_nxt;
    logic          hit;

    // A request reuses the loaded schedule only if the same key is still cached
    assign hit = KEY_CACHE_EN && cache_valid &&
                 (req_key_in == key_reg) && !key_invalidate_in;

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            key_reg     <= '0;
            data_reg    <= '0;
            cache_valid <= 1'b0;
            err_reg     <= 1'b0;
            tmo         <= '0;
            rnd         <= '0;
        end else begin
            state       <= state_nxt;
            key_reg     <= key_nxt;
            data_reg    <= data_nxt;
            cache_valid <= cache_nxt;
            err_reg     <= err_nxt;
            tmo         <= tmo_nxt;
            rnd         <= rnd_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        key_nxt   = key_reg;
        data_nxt  = data_reg;
        cache_nxt = cache_valid && !key_invalidate_in;
        err_nxt   = err_reg;
        tmo_nxt   = tmo;
        rnd_nxt   = rnd;
        unique case (state)
            IDLE: begin
                if (req_valid_in) begin
                    key_nxt  = req_key_in;
                    data_nxt = req_data_in;
                    err_nxt  = 1'b0;
                    tmo_nxt  = '0;
                    rnd_nxt  = 4'd1;
                    if (hit) begin
                        state_nxt = WHITEN;
                    end else begin
                        state_nxt = EXPAND;
                        cache_nxt = 1'b0;
                    end
                end
            end
            EXPAND: begin
                // A done pulse beats a simultaneous timeout
                if (km_key_expanded_in) begin
                    cache_nxt = !key_invalidate_in;
                    state_nxt = WHITEN;
                end else if (tmo == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    cache_nxt = 1'b0;
                    data_nxt  = '0;
                    state_nxt = DONE;
                end else begin
                    tmo_nxt = tmo + 1'b1;
                end
            end
            WHITEN: begin
                data_nxt  = data_reg ^ km_round_key_in;
                rnd_nxt   = 4'd1;
                state_nxt = ROUND;
            end
            ROUND: begin
                data_nxt = rnd_result_in;
                if (rnd == 4'd10) begin
                    state_nxt = DONE;
                end else begin
                    rnd_nxt = rnd + 4'd1;
                end
            end
            DONE: begin
                if (resp_ready_in) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; all quiet in IDLE
    always_comb begin
        req_ready_out   = (state == IDLE);
        busy_out        = (state != IDLE);
        km_init_out     = (state == EXPAND) && (tmo == '0);
        km_key_out      = key_reg;
        km_round_rd_out = (state == ROUND) ? rnd : 4'd0;
        rnd_state_out   = (state == ROUND) ? data_reg : '0;
        rnd_key_out     = (state == ROUND) ? km_round_key_in : '0;
        rnd_last_out    = (state == ROUND) && (rnd == 4'd10);
        resp_valid_out  = (state == DONE);
        resp_err_out    = (state == DONE) && err_reg;
        resp_data_out   = ((state == DONE) && !err_reg) ? data_reg : '0;
    end

endmodule

// File: tb/tb_aes_encrypt_controller.sv
// Bench for aes_encrypt_controller: behavioural key memory and round unit,
// FIPS-197 vectors, queue-based scoreboard checked by an independent monitor.
module tb_aes_encrypt_controller;

    localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk_in;
    logic         rst_n_in;
    logic         req_valid_in;
    logic         req_ready_out;
    logic [127:0] req_key_in;
    logic [127:0] req_data_in;
    logic         resp_valid_out;
    logic         resp_ready_in;
    logic [127:0] resp_data_out;
    logic         resp_err_out;
    logic         key_invalidate_in;
    logic         km_init_out;
    logic [127:0] km_key_out;
    logic         km_key_expanded_in;
    logic [3:0]   km_round_rd_out;
    logic [127:0] km_round_key_in;
    logic [127:0] rnd_state_out;
    logic [127:0] rnd_key_out;
    logic         rnd_last_out;
    logic [127:0] rnd_result_in;
    logic         busy_out;

    aes_encrypt_controller #(
        .EXPAND_TIMEOUT(32),
        .KEY_CACHE_EN(1'b1)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .req_valid_in(req_valid_in),
        .req_ready_out(req_ready_out),
        .req_key_in(req_key_in),
        .req_data_in(req_data_in),
        .resp_valid_out(resp_valid_out),
        .resp_ready_in(resp_ready_in),
        .resp_data_out(resp_data_out),
        .resp_err_out(resp_err_out),
        .key_invalidate_in(key_invalidate_in),
        .km_init_out(km_init_out),
        .km_key_out(km_key_out),
        .km_key_expanded_in(km_key_expanded_in),
        .km_round_rd_out(km_round_rd_out),
        .km_round_key_in(km_round_key_in),
        .rnd_state_out(rnd_state_out),
        .rnd_key_out(rnd_key_out),
        .rnd_last_out(rnd_last_out),
        .rnd_result_in(rnd_result_in),
        .busy_out(busy_out)
    );

    typedef struct {
        logic [127:0] data;
        logic         err;
        int           acc;
        int           lat;
    } exp_t;

    exp_t          sb_q[$];
    int            checks;
    int            passes;
    int            cyc;
    int            init_cnt;
    int            first_cyc;
    logic          seen_prev;
    logic          never_done;
    logic [1407:0] rk_flat;
    int            km_cnt;

    function automatic logic [7:0] sb(input logic [7:0] x);
        int idx;
        idx = 2047 - 8 * int'(x);
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   m [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sb(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = a[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) m[r+4*c] = b[r+4*c];
            end else begin
                m[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
                m[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
                m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
                m[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i] ^ k[127-8*i -: 8];
        return o;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
        return r;
    endfunction

    // Round-key lookup and round unit are combinational, as in the datapath
    always_comb begin
        km_round_key_in = '0;
        if (km_round_rd_out <= 4'd10)
            km_round_key_in = rk_flat[1407-128*int'(km_round_rd_out) -: 128];
        rnd_result_in = aes_round(rnd_state_out, rnd_key_out, rnd_last_out);
    end

    // Key memory: expands on init, signals done a few cycles later
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            km_cnt             <= 0;
            km_key_expanded_in <= 1'b0;
        end else begin
            km_key_expanded_in <= (km_cnt == 1) && !never_done;
            if (km_init_out) begin
                rk_flat <= expand(km_key_out);
                km_cnt  <= 4;
            end else if (km_cnt != 0) begin
                km_cnt <= km_cnt - 1;
            end
        end
    end

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_in);
            cyc++;
        end
    end

    initial begin
        init_cnt = 0;
        forever begin
            @(negedge clk_in);
            if (km_init_out) init_cnt++;
        end
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every response handshake
    initial begin
        exp_t e;
        seen_prev = 1'b0;
        first_cyc = 0;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                seen_prev = 1'b0;
            end else begin
                if (resp_valid_out && !seen_prev) first_cyc = cyc;
                seen_prev = resp_valid_out;
                if (resp_valid_out && resp_ready_in) begin
                    seen_prev = 1'b0;
                    if (sb_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_resp: got %h expected no response",
                                 resp_data_out);
                    end else begin
                        e = sb_q.pop_front();
                        chk("resp_data", resp_data_out, e.data);
                        chk("resp_err", 128'(resp_err_out), 128'(e.err));
                        if (e.lat > 0)
                            chk("latency", 128'(first_cyc - e.acc), 128'(e.lat));
                    end
                end
            end
        end
    end

    task automatic issue(input logic [127:0] key, input logic [127:0] pt,
                         input logic [127:0] ct, input logic err, input int lat);
        int   k;
        exp_t e;
        @(posedge clk_in);
        #1;
        req_key_in   = key;
        req_data_in  = pt;
        req_valid_in = 1'b1;
        k = 0;
        while (!req_ready_out && k < 100) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        if (!req_ready_out) begin
            checks++;
            $display("FAIL accept: got ready=0 expected ready=1 within 100 cycles");
            req_valid_in = 1'b0;
            return;
        end
        e = '{ct, err, cyc, lat};
        sb_q.push_back(e);
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || busy_out) && k < 200) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        checks++;
        if (k < 200) passes++;
        else $display("FAIL %s_timeout: got no response in %0d cycles expected one", name, k);
    endtask

    task automatic req(input string name, input logic [127:0] key,
                       input logic [127:0] pt, input logic [127:0] ct,
                       input int lat, input int exp_init);
        int n0;
        n0 = init_cnt;
        issue(key, pt, ct, 1'b0, lat);
        drain(name);
        chk({name, "_init"}, 128'(init_cnt - n0), 128'(exp_init));
    endtask

    task automatic pulse_invalidate();
        @(posedge clk_in);
        #1;
        key_invalidate_in = 1'b1;
        @(posedge clk_in);
        #1;
        key_invalidate_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int   n0;
        int   k;
        logic stable;
        checks            = 0;
        passes            = 0;
        never_done        = 1'b0;
        rst_n_in          = 1'b0;
        req_valid_in      = 1'b0;
        req_key_in        = '0;
        req_data_in       = '0;
        resp_ready_in     = 1'b1;
        key_invalidate_in = 1'b0;
        rk_flat           = '0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("rst_ready", 128'(req_ready_out), 128'(1));
        chk("rst_busy", 128'(busy_out), 128'(0));
        chk("rst_valid", 128'(resp_valid_out), 128'(0));
        chk("rst_init", 128'(km_init_out), 128'(0));
        chk("rst_rd", 128'(km_round_rd_out), 128'(0));
        chk("rst_last", 128'(rnd_last_out), 128'(0));
        chk("rst_data", resp_data_out, 128'(0));

        // FIPS-197 C.1, then a cache hit on the same key
        req("c1", C1K, C1P, C1C, 0, 1);
        req("c1_hit", C1K, C1P, C1C, 12, 0);

        // FIPS-197 appendix B key forces a re-expansion
        req("b", BK, BP, BC, 0, 1);

        // Invalidate in IDLE, then invalidate while rounds are running
        pulse_invalidate();
        req("b_inv", BK, BP, BC, 0, 1);
        n0 = init_cnt;
        issue(BK, BP, BC, 1'b0, 12);
        repeat (4) @(posedge clk_in);
        #1;
        key_invalidate_in = 1'b1;
        @(posedge clk_in);
        #1;
        key_invalidate_in = 1'b0;
        drain("b_inv_round");
        chk("b_inv_round_init", 128'(init_cnt - n0), 128'(0));
        req("b_after_inv", BK, BP, BC, 0, 1);

        // Key memory never answers: timeout error, then a clean re-expansion
        never_done = 1'b1;
        n0 = init_cnt;
        issue(C1K, C1P, 128'(0), 1'b1, 33);
        drain("tmo");
        chk("tmo_init", 128'(init_cnt - n0), 128'(1));
        never_done = 1'b0;
        req("after_tmo", C1K, C1P, C1C, 0, 1);

        // Consumer stalls for 20 cycles
        resp_ready_in = 1'b0;
        issue(C1K, C1P, C1C, 1'b0, 12);
        k = 0;
        while (!resp_valid_out && k < 50) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        stable = 1'b1;
        repeat (20) begin
            if (resp_data_out !== C1C || resp_valid_out !== 1'b1 || req_ready_out !== 1'b0)
                stable = 1'b0;
            @(posedge clk_in);
            #1;
        end
        chk("hold_stable", 128'(stable), 128'(1));
        resp_ready_in = 1'b1;
        drain("hold");

        // Asynchronous reset in the middle of the rounds
        issue(C1K, C1P, C1C, 1'b0, 12);
        repeat (5) @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        sb_q.delete();
        chk("arst_busy", 128'(busy_out), 128'(0));
        chk("arst_ready", 128'(req_ready_out), 128'(1));
        chk("arst_rd", 128'(km_round_rd_out), 128'(0));
        chk("arst_state", rnd_state_out, 128'(0));
        chk("arst_key", km_key_out, 128'(0));
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        repeat (15) @(posedge clk_in);
        #1;
        chk("arst_no_resp", 128'(resp_valid_out), 128'(0));
        req("after_rst", C1K, C1P, C1C, 0, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
